// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver clocked straight off the system clock, mid-bit sampling, start-glitch and stop-bit checks.
// Latency: byte/error pulse one cycle after the stop-bit decision at t0+HALF+9*CLKS_PER_BIT (+1 with majority voting).
// Backpressure: none; rx_data holds until the next good byte, pulses are single-cycle and must be consumed on sight.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote over centre-1/centre/centre+1 samples, decided at centre+1.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    // The counter is cleared on the edge that enters START, so the edge at
    // t0+k sees clk_cnt == k-1. The vote needs one extra clock to see centre+1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_PT = CW'(HALF);
`else
    localparam logic [CW-1:0] START_PT = CW'(HALF - 1);
`endif
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_frame_err_q, rx_frame_err_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            smp;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keep the two previous synchronized samples for the 2-of-3 vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    // hist_q[1] = centre-1, hist_q[0] = centre, rx_s = centre+1
    assign smp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign smp = rx_s;
`endif

    // Receiver state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            clk_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    // Next-state: start detect, glitch reject, bit sampling, stop framing
    always_comb begin
        state_d        = state_q;
        clk_cnt_d      = clk_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == START_PT) begin
                    clk_cnt_d = '0;
                    // A line back high at mid start bit is noise, not a frame
                    state_d   = smp ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {smp, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (smp) begin
                        // Returning to IDLE at stop centre catches a back-to-back start edge
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        state_d        = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line idles so a break reports one error only
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: scoreboard bench for the 8N1 receiver at a short bit period.
// Latency: expected pulses carry the exact cycle they must appear on.
// Backpressure: n/a.
module tb_uart_rx_8n1;

    localparam int N    = 40;
    localparam int HALF = N / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // rx falls before edge E; t0 = E+2; stop decided at t0+HALF+9N(+1)
    localparam int LAT = 2 + HALF + 9 * N + MAJ;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_NONE  = 2;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   busy_rise_cyc = -1;
    logic busy_prev = 1'b0;
    exp_t sb[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every pulse
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (rx_busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = rx_busy;
        if (rx_valid || rx_frame_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rx_valid, rx_frame_err}, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("pulse_kind", {30'd0, rx_valid, rx_frame_err}, x.ferr ? 32'd1 : 32'd2);
                chk("rx_data", rx_data, x.data);
                chk("pulse_cycle", cyc, x.cyc);
            end
        end
    end

    // Drive ncyc clocks of one frame; optional 1-clock high glitch at each data-bit centre
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit glitch,
                              input int kind, input logic [7:0] edata, input int ncyc,
                              output int e);
        exp_t x;
        int   k;
        logic lvl;
        e = 0;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            if (j == 0) begin
                e = cyc + 1;
                if (kind != K_NONE) begin
                    x.ferr = (kind == K_FERR);
                    x.data = edata;
                    x.cyc  = e + LAT;
                    sb.push_back(x);
                end
            end
            k = j / N;
            if (k == 0)      lvl = 1'b0;
            else if (k <= 8) lvl = d[k-1];
            else             lvl = stop_b;
            if (glitch && k >= 1 && k <= 8 && (j % N) == HALF) lvl = 1'b1;
            rx = lvl;
        end
    endtask

    initial begin
        int e;
        int r;
        logic [7:0] maj_exp;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_frame_err", rx_frame_err, 1'b0);
        chk("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Short low pulse while idle: busy blips, no pulse, data unchanged
        @(negedge clk);
        e = cyc + 1;
        rx = 1'b0;
        repeat (9) @(negedge clk);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("glitch_busy_rise", busy_rise_cyc, e + 2);
        chk("glitch_busy_low", rx_busy, 1'b0);
        chk("glitch_rx_data", rx_data, 8'h00);

        // Clean byte 'K'
        send_frame(8'h4B, 1'b1, 1'b0, K_VALID, 8'h4B, 10 * N, e);
        chk("k_busy_rise", busy_rise_cyc, e + 2);
        repeat (N) @(negedge clk);

        // Stop bit low then line held low: one error, data kept, busy drops 2 clocks after release
        send_frame(8'hA5, 1'b0, 1'b0, K_FERR, 8'h4B, 10 * N, e);
        repeat (200) @(negedge clk);
        @(negedge clk);
        r  = cyc + 1;
        rx = 1'b1;
        while (cyc < r + 1) begin
            @(posedge clk);
            #1;
        end
        chk("wait_idle_busy_hold", rx_busy, 1'b1);
        @(posedge clk);
        #1;
        chk("wait_idle_busy_drop", rx_busy, 1'b0);
        repeat (N) @(negedge clk);

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b1, 1'b0, K_VALID, 8'h55, 10 * N, e);
        send_frame(8'hAA, 1'b1, 1'b0, K_VALID, 8'hAA, 10 * N, e);
        repeat (N) @(negedge clk);

        // Reset in the middle of data bit 4, then a fresh byte
        send_frame(8'hFF, 1'b1, 1'b0, K_NONE, 8'h00, HALF + 5 * N, e);
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        chk("abort_rx_data", rx_data, 8'h00);
        chk("abort_rx_busy", rx_busy, 1'b0);
        chk("abort_rx_valid", rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("abort_idle_busy", rx_busy, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, K_VALID, 8'h3C, 10 * N, e);
        repeat (N) @(negedge clk);

        // 0x00 with a one-clock high glitch at every data-bit centre
`ifdef UART_RX_MAJORITY_EN
        maj_exp = 8'h00;
`else
        maj_exp = 8'hFF;
`endif
        send_frame(8'h00, 1'b1, 1'b1, K_VALID, maj_exp, 10 * N, e);
        repeat (2 * N) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
